// File: rtl/y_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : y_out_ctrl
// Brief    : Output adder sequencer for y = group_sum + xD. Buffers the early
//            xD stream, pairs each group_sum with the oldest xD, issues pairs
//            to fixed-latency FP16 lane adders, predicts result arrival with a
//            shift register and lands results in a credit-protected FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module y_out_ctrl #(
    parameter  int DW        = 16,
    parameter  int H_TILE    = 1,
    parameter  int P_TILE    = 1,
    parameter  int A_LAT     = 11,
    parameter  int XD_DEPTH  = 4,
    parameter  int OUT_DEPTH = 16,
    localparam int W         = H_TILE * P_TILE * DW
) (
    input  logic         clk,
    input  logic         rstn,
    // xD stream
    input  logic         xd_valid_i,
    output logic         xd_ready_o,
    input  logic [W-1:0] xd_i,
    // group_sum stream
    input  logic         gs_valid_i,
    output logic         gs_ready_o,
    input  logic [W-1:0] gs_i,
    // adder lanes
    output logic         add_valid_o,
    output logic [W-1:0] add_a_o,
    output logic [W-1:0] add_b_o,
    input  logic         add_valid_i,
    input  logic [W-1:0] add_sum_i,
    // y stream
    output logic         y_valid_o,
    input  logic         y_ready_i,
    output logic [W-1:0] y_o,
    // status
    output logic         busy_o,
    output logic         err_o
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_XD_AW   = $clog2(XD_DEPTH);
    localparam int c_OUT_AW  = $clog2(OUT_DEPTH);
    localparam int c_CNT_W   = c_OUT_AW + 1;
    localparam int c_OCC_W   = c_CNT_W + 1;
    localparam int c_BLANK_W = $clog2(A_LAT + 2);

    localparam logic [c_BLANK_W-1:0] c_BLANK_INIT = c_BLANK_W'(A_LAT + 1);
    localparam logic [c_BLANK_W-1:0] c_BLANK_ONE  = c_BLANK_W'(1);
    localparam logic [c_XD_AW:0]     c_XD_PTR_ONE = (c_XD_AW + 1)'(1);
    localparam logic [c_OUT_AW:0]    c_OUT_PTR_ONE = (c_OUT_AW + 1)'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_OCC_W-1:0]   c_OCC_LIMIT  = c_OCC_W'(OUT_DEPTH);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [c_BLANK_W-1:0] r_blank_cnt;
    logic                 w_blanking;

    logic [W-1:0]         r_xd_mem [XD_DEPTH];
    logic [c_XD_AW:0]     r_xd_wr_ptr;
    logic [c_XD_AW:0]     r_xd_rd_ptr;
    logic                 w_xd_empty;
    logic                 w_xd_full;
    logic                 w_xd_push;
    logic [W-1:0]         w_xd_head;

    logic [W-1:0]         r_out_mem [OUT_DEPTH];
    logic [c_OUT_AW:0]    r_out_wr_ptr;
    logic [c_OUT_AW:0]    r_out_rd_ptr;
    logic [c_CNT_W-1:0]   w_out_count;
    logic                 w_out_empty;
    logic                 w_out_full;
    logic                 w_out_push;
    logic                 w_out_pop;

    logic [c_CNT_W-1:0]   r_inflight;
    logic [c_OCC_W-1:0]   w_occ;
    logic                 w_credit_ok;

    logic                 w_gs_ready;
    logic                 w_issue;
    logic                 r_add_valid;
    logic [W-1:0]         r_add_a;
    logic [W-1:0]         r_add_b;

    logic                 w_pred;
    logic                 w_ret;
    logic                 w_timing_err;
    logic                 w_ovf_err;
    logic                 r_err;

    // ------------------------------------------------------------------------
    // Blanking: after reset the adder pipeline is not cleared, so anything it
    // emits during the first A_LAT+1 cycles is stale and must be ignored.
    // ------------------------------------------------------------------------
    assign w_blanking = (r_blank_cnt != '0);

    // Blanking counter: loaded on reset, counts down to zero and stays there
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_blank_cnt <= c_BLANK_INIT;
        end else if (w_blanking) begin
            r_blank_cnt <= r_blank_cnt - c_BLANK_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // xD FIFO (no bypass: a word written at T is first visible at T+1)
    // ------------------------------------------------------------------------
    assign w_xd_empty = (r_xd_wr_ptr == r_xd_rd_ptr);
    assign w_xd_full  = (r_xd_wr_ptr[c_XD_AW] != r_xd_rd_ptr[c_XD_AW]) &&
                        (r_xd_wr_ptr[c_XD_AW-1:0] == r_xd_rd_ptr[c_XD_AW-1:0]);
    assign w_xd_push  = xd_valid_i && !w_xd_full;
    assign w_xd_head  = r_xd_mem[r_xd_rd_ptr[c_XD_AW-1:0]];
    assign xd_ready_o = !w_xd_full;

    // xD storage write
    always_ff @(posedge clk) begin
        if (w_xd_push) begin
            r_xd_mem[r_xd_wr_ptr[c_XD_AW-1:0]] <= xd_i;
        end
    end

    // xD pointers: push on accepted xD, pop on every issue
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_xd_wr_ptr <= '0;
            r_xd_rd_ptr <= '0;
        end else begin
            if (w_xd_push) begin
                r_xd_wr_ptr <= r_xd_wr_ptr + c_XD_PTR_ONE;
            end
            if (w_issue) begin
                r_xd_rd_ptr <= r_xd_rd_ptr + c_XD_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Credit: a slot is reserved at issue time, so buffered + in-flight
    // results can never exceed the output FIFO capacity.
    // ------------------------------------------------------------------------
    assign w_occ       = {1'b0, w_out_count} + {1'b0, r_inflight};
    assign w_credit_ok = (w_occ < c_OCC_LIMIT);

    // Readiness is built only from registered state
    assign w_gs_ready = !w_blanking && !w_xd_empty && w_credit_ok;
    assign w_issue    = gs_valid_i && w_gs_ready;
    assign gs_ready_o = w_gs_ready;

    // Issue register: one-cycle strobe, operands hold between issues
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_add_valid <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
        end else begin
            r_add_valid <= w_issue;
            if (w_issue) begin
                r_add_a <= gs_i;
                r_add_b <= w_xd_head;
            end
        end
    end

    assign add_valid_o = r_add_valid;
    assign add_a_o     = r_add_a;
    assign add_b_o     = r_add_b;

    // ------------------------------------------------------------------------
    // Prediction: the issue strobe delayed by exactly A_LAT cycles marks the
    // slot in which the adder result is due.
    // ------------------------------------------------------------------------
    generate
        if (A_LAT == 1) begin : g_pred_lat1
            logic r_pred;

            // Single-stage prediction delay
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_pred <= 1'b0;
                end else begin
                    r_pred <= r_add_valid;
                end
            end

            assign w_pred = r_pred;
        end else begin : g_pred_latn
            logic [A_LAT-1:0] r_pred_sr;

            // Multi-stage prediction shift register
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_pred_sr <= '0;
                end else begin
                    r_pred_sr <= {r_pred_sr[A_LAT-2:0], r_add_valid};
                end
            end

            assign w_pred = r_pred_sr[A_LAT-1];
        end
    endgenerate

    // The FIFO write is driven by the prediction, never by the adder's valid
    assign w_ret        = w_pred && !w_blanking;
    assign w_timing_err = !w_blanking && (add_valid_i != w_pred);
    assign w_ovf_err    = w_ret && w_out_full;

    // In-flight counter: +1 on issue, -1 on predicted return
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + c_CNT_ONE;
                2'b01:   r_inflight <= r_inflight - c_CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    assign w_out_count = r_out_wr_ptr - r_out_rd_ptr;
    assign w_out_empty = (r_out_wr_ptr == r_out_rd_ptr);
    assign w_out_full  = (r_out_wr_ptr[c_OUT_AW] != r_out_rd_ptr[c_OUT_AW]) &&
                         (r_out_wr_ptr[c_OUT_AW-1:0] == r_out_rd_ptr[c_OUT_AW-1:0]);
    assign w_out_push  = w_ret && !w_out_full;
    assign w_out_pop   = !w_out_empty && y_ready_i;

    // Result storage write
    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wr_ptr[c_OUT_AW-1:0]] <= add_sum_i;
        end
    end

    // Output pointers: push on predicted return, pop on y handshake
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_wr_ptr <= '0;
            r_out_rd_ptr <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wr_ptr <= r_out_wr_ptr + c_OUT_PTR_ONE;
            end
            if (w_out_pop) begin
                r_out_rd_ptr <= r_out_rd_ptr + c_OUT_PTR_ONE;
            end
        end
    end

    // Head is masked while empty so stale storage never shows on y_o
    assign y_valid_o = !w_out_empty;
    assign y_o       = w_out_empty ? '0 : r_out_mem[r_out_rd_ptr[c_OUT_AW-1:0]];

    // ------------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------------
    // Sticky error: adder timing mismatch or a push into a full FIFO
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_timing_err || w_ovf_err) begin
            r_err <= 1'b1;
        end
    end

    assign err_o  = r_err;
    assign busy_o = !w_xd_empty || (r_inflight != '0) || !w_out_empty || w_blanking;

endmodule
`default_nettype wire

// File: tb/tb_y_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_out_ctrl
// Brief    : Self-checking bench for y_out_ctrl with a behavioural FP16
//            adder pipeline that can be made to answer one cycle late.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y_out_ctrl;

    localparam int DW        = 16;
    localparam int A_LAT     = 11;
    localparam int XD_DEPTH  = 4;
    localparam int OUT_DEPTH = 16;
    localparam int W         = DW;

    logic         clk = 1'b0;
    logic         rstn;
    logic         xd_valid_i;
    logic         xd_ready_o;
    logic [W-1:0] xd_i;
    logic         gs_valid_i;
    logic         gs_ready_o;
    logic [W-1:0] gs_i;
    logic         add_valid_o;
    logic [W-1:0] add_a_o;
    logic [W-1:0] add_b_o;
    logic         add_valid_i;
    logic [W-1:0] add_sum_i;
    logic         y_valid_o;
    logic         y_ready_i;
    logic [W-1:0] y_o;
    logic         busy_o;
    logic         err_o;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] xq[$];

    y_out_ctrl #(
        .DW        (DW),
        .H_TILE    (1),
        .P_TILE    (1),
        .A_LAT     (A_LAT),
        .XD_DEPTH  (XD_DEPTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .xd_valid_i  (xd_valid_i),
        .xd_ready_o  (xd_ready_o),
        .xd_i        (xd_i),
        .gs_valid_i  (gs_valid_i),
        .gs_ready_o  (gs_ready_o),
        .gs_i        (gs_i),
        .add_valid_o (add_valid_o),
        .add_a_o     (add_a_o),
        .add_b_o     (add_b_o),
        .add_valid_i (add_valid_i),
        .add_sum_i   (add_sum_i),
        .y_valid_o   (y_valid_o),
        .y_ready_i   (y_ready_i),
        .y_o         (y_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // FP16 add for positive normal operands, truncating
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [11:0] mx, my, s;
        logic [4:0]  e;
        if (a[14:10] < b[14:10]) begin x = b; y = a; end
        else begin x = a; y = b; end
        mx = {2'b01, x[9:0]};
        my = {2'b01, y[9:0]};
        my = my >> (x[14:10] - y[14:10]);
        s  = mx + my;
        if (s[11]) begin
            e = x[14:10] + 5'd1;
            return {1'b0, e, s[10:1]};
        end
        return {1'b0, x[14:10], s[9:0]};
    endfunction

    // Behavioural adder: not reset by rstn, optional one-cycle-late tap
    logic            model_clr;
    logic            late_mode;
    logic [A_LAT:0]  pv;
    logic [15:0]     ps [0:A_LAT];

    always @(posedge clk) begin
        if (model_clr) begin
            pv <= '0;
        end else begin
            pv    <= {pv[A_LAT-1:0], add_valid_o};
            ps[0] <= add_valid_o ? fp16_add(add_a_o, add_b_o) : 16'h0000;
            for (int i = 1; i <= A_LAT; i++) ps[i] <= ps[i-1];
        end
    end

    assign add_valid_i = late_mode ? pv[A_LAT] : pv[A_LAT-1];
    assign add_sum_i   = late_mode ? ps[A_LAT] : ps[A_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one gs (xD already poppable) and follow it to the y output
    task automatic issue_check(input logic [15:0] gs, input logic [15:0] xd, input logic [15:0] y);
        check("err_clear", err_o, 0);
        gs_valid_i = 1'b1;
        gs_i       = gs;
        check("gs_ready", gs_ready_o, 1);
        tick();
        gs_valid_i = 1'b0;
        check("add_valid", add_valid_o, 1);
        check("add_a", add_a_o, gs);
        check("add_b", add_b_o, xd);
        tick();
        check("add_valid_pulse", add_valid_o, 0);
        for (int k = 0; k < A_LAT - 1; k++) tick();
        check("y_early", y_valid_o, 0);
        tick();
        check("y_valid", y_valid_o, 1);
        check("y_data", y_o, y);
        tick();
        check("y_popped", y_valid_o, 0);
        check("idle", busy_o, 0);
    endtask

    task automatic run_pair(input logic [15:0] xd, input logic [15:0] gs,
                            input logic [15:0] y, input int gap);
        xd_valid_i = 1'b1;
        xd_i       = xd;
        check("xd_ready", xd_ready_o, 1);
        check("no_bypass", gs_ready_o, 0);
        tick();
        xd_valid_i = 1'b0;
        for (int k = 1; k < gap; k++) tick();
        issue_check(gs, xd, y);
    endtask

    // Collect n results against the scoreboard, optionally on consecutive cycles
    task automatic drain(input int n, input int budget, input bit consec);
        int got  = 0;
        int last = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (y_valid_o) begin
                check("y_order", y_o, exp_q.pop_front());
                if (consec && got > 0) check("y_consecutive", c, last + 1);
                last = c;
                got++;
            end
            tick();
        end
        check("y_count", got, n);
    endtask

    typedef struct {
        logic [15:0] xd;
        logic [15:0] gs;
        logic [15:0] y;
        int          gap;
    } pair_t;

    pair_t vec [5];

    initial begin
        int xd_sent;
        int gs_sent;
        int stale;
        logic [15:0] xb [4];
        logic [15:0] gb [4];

        vec[0] = '{xd: 16'h3C00, gs: 16'h4000, y: 16'h4200, gap: 15}; // 1.0 + 2.0 = 3.0
        vec[1] = '{xd: 16'h3C00, gs: 16'h3C00, y: 16'h4000, gap: 3};  // 1.0 + 1.0 = 2.0
        vec[2] = '{xd: 16'h3800, gs: 16'h3E00, y: 16'h4000, gap: 1};  // 0.5 + 1.5 = 2.0
        vec[3] = '{xd: 16'h3C00, gs: 16'h4200, y: 16'h4400, gap: 2};  // 1.0 + 3.0 = 4.0
        vec[4] = '{xd: 16'h4200, gs: 16'h4500, y: 16'h4800, gap: 1};  // 3.0 + 5.0 = 8.0

        rstn       = 1'b0;
        model_clr  = 1'b1;
        late_mode  = 1'b0;
        xd_valid_i = 1'b0;
        xd_i       = '0;
        gs_valid_i = 1'b0;
        gs_i       = '0;
        y_ready_i  = 1'b1;
        tick(); tick(); tick();

        // Reset state
        check("rst_add_valid", add_valid_o, 0);
        check("rst_add_a", add_a_o, 0);
        check("rst_add_b", add_b_o, 0);
        check("rst_y_valid", y_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_gs_ready", gs_ready_o, 0);
        check("rst_xd_ready", xd_ready_o, 1);
        check("rst_busy", busy_o, 1);

        // Cycle 0 after release; first xD lands at cycle 5, first gs at 20
        model_clr = 1'b0;
        rstn      = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        for (int i = 0; i < 5; i++) run_pair(vec[i].xd, vec[i].gs, vec[i].y, vec[i].gap);

        // Starvation: gs offered with xD empty is not accepted
        gs_valid_i = 1'b1;
        gs_i       = 16'h4000;
        for (int k = 0; k < 3; k++) begin
            check("starve_gs_ready", gs_ready_o, 0);
            tick();
        end
        gs_valid_i = 1'b0;

        // Back-to-back: 4 xD fill the FIFO, 4 gs on consecutive cycles
        xb = '{16'h3C00, 16'h3800, 16'h4000, 16'h4200};
        gb = '{16'h4000, 16'h3C00, 16'h4200, 16'h4500};
        for (int k = 0; k < 4; k++) begin
            xd_valid_i = 1'b1;
            xd_i       = xb[k];
            check("b2b_xd_ready", xd_ready_o, 1);
            xq.push_back(xb[k]);
            tick();
        end
        xd_i = 16'hDEAD;
        check("xd_full", xd_ready_o, 0);
        for (int k = 0; k < 4; k++) begin
            gs_valid_i = 1'b1;
            gs_i       = gb[k];
            check("b2b_gs_ready", gs_ready_o, 1);
            exp_q.push_back(fp16_add(gb[k], xq.pop_front()));
            tick();
            xd_valid_i = 1'b0;
            if (k == 0) check("xd_ready_after_pop", xd_ready_o, 1);
        end
        gs_valid_i = 1'b0;
        drain(4, 40, 1'b1);
        check("b2b_idle", busy_o, 0);

        // Backpressure: 20 pairs offered while y is stalled
        y_ready_i = 1'b0;
        xd_sent   = 0;
        gs_sent   = 0;
        for (int c = 0; c < 60; c++) begin
            xd_valid_i = (xd_sent < 20);
            xd_i       = 16'h3C00 + 16'(xd_sent);
            gs_valid_i = (gs_sent < 20);
            gs_i       = 16'h4000 + 16'(gs_sent * 16);
            if (xd_valid_i && xd_ready_o) begin
                xq.push_back(xd_i);
                xd_sent++;
            end
            if (gs_valid_i && gs_ready_o) begin
                exp_q.push_back(fp16_add(gs_i, xq.pop_front()));
                gs_sent++;
            end
            tick();
        end
        xd_valid_i = 1'b0;
        gs_valid_i = 1'b0;
        check("bp_accepted", gs_sent, 16);
        check("bp_xd_sent", xd_sent, 20);
        check("bp_xd_full", xd_ready_o, 0);
        check("bp_y_valid", y_valid_o, 1);
        check("bp_err", err_o, 0);
        gs_valid_i = 1'b1;
        gs_i       = 16'h4000 + 16'(gs_sent * 16);
        check("bp_stalled", gs_ready_o, 0);
        gs_valid_i = 1'b0;
        y_ready_i  = 1'b1;
        check("bp_first_y", y_o, exp_q.pop_front());
        tick();
        check("bp_credit_return", gs_ready_o, 1);
        drain(15, 40, 1'b1);
        for (int c = 0; c < 20 && gs_sent < 20; c++) begin
            gs_valid_i = 1'b1;
            gs_i       = 16'h4000 + 16'(gs_sent * 16);
            if (gs_ready_o) begin
                exp_q.push_back(fp16_add(gs_i, xq.pop_front()));
                gs_sent++;
            end
            tick();
        end
        gs_valid_i = 1'b0;
        drain(4, 40, 1'b1);
        check("bp_all_issued", gs_sent, 20);
        check("bp_err_end", err_o, 0);
        check("bp_idle", busy_o, 0);

        // Timing fault: adder answers one cycle late; slot value (0) is written
        late_mode = 1'b1;
        run_pair(16'h3C00, 16'h4000, 16'h0000, 2);
        check("err_set", err_o, 1);
        tick(); tick(); tick();
        check("err_sticky", err_o, 1);
        late_mode = 1'b0;

        // Reset mid-flight: 3 pairs issued, 1-cycle reset, stale returns ignored
        for (int k = 0; k < 3; k++) begin
            xd_valid_i = 1'b1;
            xd_i       = 16'h3C00 + 16'(k);
            tick();
        end
        xd_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            gs_valid_i = 1'b1;
            gs_i       = 16'h4400;
            check("mid_gs_ready", gs_ready_o, 1);
            tick();
        end
        gs_valid_i = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_add_valid", add_valid_o, 0);
        check("mid_add_a", add_a_o, 0);
        check("mid_add_b", add_b_o, 0);
        check("mid_y_valid", y_valid_o, 0);
        check("mid_gs_ready_blank", gs_ready_o, 0);
        check("mid_err", err_o, 0);
        check("mid_busy", busy_o, 1);
        check("mid_xd_ready", xd_ready_o, 1);
        xd_valid_i = 1'b1;
        xd_i       = 16'h3C00;
        tick();
        xd_valid_i = 1'b0;
        stale = 0;
        for (int k = 0; k < 11; k++) begin
            if (add_valid_i) stale++;
            check("blank_busy", busy_o, 1);
            check("blank_y_valid", y_valid_o, 0);
            check("blank_err", err_o, 0);
            check("blank_gs_ready", gs_ready_o, 0);
            tick();
        end
        check("stale_pulses", stale, 3);
        check("blank_end_gs_ready", gs_ready_o, 1);
        issue_check(16'h4000, 16'h3C00, 16'h4200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y_out_ctrl.md
# y_out_ctrl

Controller and sequencer for the SSM output adder (y = group_sum + xD). It decouples the early-arriving xD vector stream from the late-arriving group_sum stream and pairs them in order. It issues each pair to the shared fixed-latency FP16 lane adders and tracks results in flight. Results land in a back-pressurable output FIFO, so the non-stallable adder never overflows downstream.

## Interface
- DW, 16, element width (FP16)
- H_TILE, 1, head tile; P_TILE, 1, headdim tile; W = H_TILE*P_TILE*DW
- A_LAT, 11, adder latency, add_valid_o to add_valid_i, cycles (≥1)
- XD_DEPTH, 4, xD FIFO entries (power of 2, ≥2)
- OUT_DEPTH, 16, output FIFO entries (power of 2, ≥2)

- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- xd_valid_i / xd_ready_o  in/out  1/1  xD stream handshake
- xd_i  in  W  xD vector
- gs_valid_i / gs_ready_o  in/out  1/1  group_sum stream handshake
- gs_i  in  W  group_sum vector
- add_valid_o  out  1  issue strobe to all adder lanes
- add_a_o / add_b_o  out  W/W  group_sum / xD operands
- add_valid_i  in  1  AND of lane valid_out
- add_sum_i  in  W  adder result
- y_valid_o / y_ready_i  out/in  1/1  output handshake
- y_o  out  W  y vector (FIFO head)
- busy_o  out  1  any data buffered, in flight, or blanking active
- err_o  out  1  sticky adder-timing error

## Operation
- Reset (rstn=0 at posedge): both FIFOs empty; in-flight counter 0; prediction shift register (A_LAT bits) cleared; err_o=0; add_valid_o=0; add_a_o/add_b_o=0. Blanking counter is loaded with A_LAT+1.
- Blanking: while the blanking counter is nonzero it decrements every cycle. During blanking gs_ready_o=0, and add_valid_i/add_sum_i are ignored, with no FIFO write and no error. This drains stale results from the unreset adder pipeline. xd_ready_o is unaffected.
- xD FIFO: a push occurs on xd_valid_i && xd_ready_o, where xd_ready_o = !xd_full. A vector written at cycle T is first poppable at T+1; there is no same-cycle bypass.
- Credit: occ = out FIFO count + inflight. credit_ok = occ < OUT_DEPTH.
- gs_ready_o = !blanking && !xd_empty && credit_ok.
- Issue on gs_valid_i && gs_ready_o:
  - pop the xD head;
  - register add_a_o=gs_i and add_b_o=xD head;
  - assert add_valid_o for exactly the next cycle;
  - inflight+1;
  - shift a 1 into the prediction register.
- Issues may occur every cycle (throughput 1). Operands hold their last value when add_valid_o=0.
- Return: the prediction register output (pred) is the issue bit delayed A_LAT cycles after add_valid_o.
  - When pred=1: write add_sum_i to the out FIFO and decrement inflight.
  - When add_valid_i != pred outside blanking: set err_o (sticky until reset). The FIFO write still follows pred, never add_valid_i.
- Simultaneous issue and return: inflight is unchanged. Simultaneous out push and pop: count is unchanged.
- The credit scheme guarantees the out FIFO never overflows. Any push attempted while full is also flagged in err_o.
- Output: y_valid_o = !out_empty. y_o is the head. The FIFO pops on y_valid_o && y_ready_i.
- Ordering: y order equals group_sum issue order, each paired with the oldest xD.
- busy_o = !xd_empty || inflight≠0 || !out_empty || blanking.

## Timing
- All outputs are registered or derived from registered state. gs_ready_o, xd_ready_o and y_valid_o have no combinational path from the same-cycle valid/ready inputs.
- Latency:
  - gs handshake at cycle T;
  - add_valid_o at T+1;
  - add_valid_i expected at T+1+A_LAT;
  - y_valid_o at T+2+A_LAT with an empty out FIFO.
- After reset release, first gs acceptance no earlier than cycle A_LAT+2, xD having been pushed before then.
- Credit stall: with y_ready_i=0, at most OUT_DEPTH issues are accepted in total. gs_ready_o drops in the cycle occ reaches OUT_DEPTH. It rises the cycle after a pop frees space.
- Reset mid-operation: all buffered and in-flight data is discarded. Late adder outputs fall inside blanking, produce no y_valid_o, and do not set err_o.

## Test plan
- Single pair with A_LAT=11: xD=0x3C00 (1.0) at cycle 5, gs=0x4000 (2.0) at cycle 20 -> add_valid_o at 21 with a=0x4000, b=0x3C00; a model adder returns at 32; y_valid_o=1 at 33 with y_o=0x4200 (3.0).
- Back-to-back: 4 xD then 4 gs on consecutive cycles, y_ready_i=1 -> 4 y outputs on consecutive cycles, in order, gs_ready_o never dropping.
- Backpressure: y_ready_i=0, 20 pairs offered with OUT_DEPTH=16 -> exactly 16 accepted, gs_ready_o=0 after; out FIFO holds 16; releasing y_ready_i drains 16, then the remaining 4 complete; err_o=0.
- xD starvation/full: gs_valid_i=1 with xD empty -> gs_ready_o=0; 4 xD pushes with XD_DEPTH=4 -> xd_ready_o=0 until the next issue pops one.
- Timing fault: the model adder returns one cycle late once -> err_o=1 from the mismatch cycle and stays 1; the slot-aligned value is written to the FIFO.
- Reset mid-flight: 3 pairs issued, rstn=0 for 1 cycle -> all outputs 0, busy_o=1 during the 12 blanking cycles; stale add_valid_i pulses ignored; err_o=0; a new pair afterwards completes normally.
